// File: rtl/mdu_hilo_if.sv
// Bus between the multicycle control/execute logic and the HI/LO multiply-divide unit.
// The master drives the request; the slave (mdu_hilo) returns status and HI/LO.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the multicycle MIPS core.
// It works on magnitudes, one operand bit per cycle, and sign-corrects in a final FIX cycle.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_hilo_if.slave bus
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_main_q, neg_main_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 is_signed_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic [WIDTH-1:0]     abs_a_s;
  logic [WIDTH-1:0]     abs_b_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic                 div_ok_s;
  logic [WIDTH-1:0]     div_rem_s;
  logic [2*WIDTH-1:0]   mul_res_s;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign is_signed_s = (bus.op == 3'd0) || (bus.op == 3'd2);
  assign a_neg_s     = is_signed_s & bus.a[WIDTH-1];
  assign b_neg_s     = is_signed_s & bus.b[WIDTH-1];
  assign abs_a_s     = neg_if(a_neg_s, bus.a);
  assign abs_b_s     = neg_if(b_neg_s, bus.b);

  // Multiply: add multiplicand into the upper half when the current multiplier bit is set, then shift right.
  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  // Divide: the low half of a restoring subtract is exact whenever the subtract does not underflow.
  assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ok_s    = div_shift_s >= {1'b0, opb_q};
  assign div_rem_s   = div_ok_s ? (div_shift_s[WIDTH-1:0] - opb_q) : div_shift_s[WIDTH-1:0];
  assign mul_res_s   = neg_main_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    dbz_d      = dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d   = bus.op[1];
              neg_main_d = a_neg_s ^ b_neg_s;
              neg_rem_d  = a_neg_s;
              dbz_d      = (bus.b == {WIDTH{1'b0}});
              cnt_d      = {CW{1'b0}};
              state_d    = ST_CALC;
              if (bus.op[1]) begin
                acc_d = {{WIDTH{1'b0}}, abs_a_s};
                opb_d = abs_b_s;
              end else begin
                acc_d = {{WIDTH{1'b0}}, abs_b_s};
                opb_d = abs_a_s;
              end
            end
            3'd4:    hi_d = bus.a;
            3'd5:    lo_d = bus.a;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (is_div_q) begin
          acc_d = {div_rem_s, acc_q[WIDTH-2:0], div_ok_s};
        end else begin
          acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (is_div_q) begin
          // Divide by zero leaves the remainder equal to the dividend; only the quotient is forced.
          hi_d = neg_if(neg_rem_q, acc_q[2*WIDTH-1:WIDTH]);
          lo_d = dbz_q ? {WIDTH{1'b1}} : neg_if(neg_main_q, acc_q[WIDTH-1:0]);
        end else begin
          hi_d = mul_res_s[2*WIDTH-1:WIDTH];
          lo_d = mul_res_s[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      opb_q      <= {WIDTH{1'b0}};
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
